// File: rtl/xbar_route_loader_pkg.sv
// Shared definitions for the crossbar route loader: request opcodes, FSM states,
// default address geometry and the toggle-address helper.
package xbar_route_loader_pkg;

    typedef enum logic [1:0] {
        OP_CONNECT    = 2'b00,
        OP_DISCONNECT = 2'b01,
        OP_CLEAR      = 2'b10,
        OP_RSVD       = 2'b11
    } req_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StDrop,
        StDropGap,
        StSet,
        StSetGap,
        StClr,
        StClrGap,
        StDone
    } state_e;

    localparam int unsigned DEF_ADDR_W    = 5;
    localparam int unsigned DEF_REST_ADDR = (32'd1 << DEF_ADDR_W) - 32'd1;

    // Ceiling log2, never below 1 so index ports stay at least one bit wide.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < value) begin
            w++;
        end
        return (w == 0) ? 32'd1 : w;
    endfunction

    // All-ones address: the crossbar ignores it, so it is the idle value.
    function automatic int unsigned rest_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

    // Crossbar toggle address for a given input/output pair.
    function automatic int unsigned toggle_addr(input int unsigned in_idx,
                                                input int unsigned out_idx,
                                                input int unsigned out_cnt);
        return in_idx * out_cnt + out_idx;
    endfunction

endpackage

// File: rtl/xbar_req_fifo.sv
// Small synchronous request FIFO with asynchronous active-high reset.
// Head entry is presented combinationally on rdata whenever empty is low.
module xbar_req_fifo
    import xbar_route_loader_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = clog2(Depth);
    localparam int unsigned CntW = clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = (32'(count_q) == Depth);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (32'(ptr) == Depth - 1) ? '0 : ptr + PtrW'(1);
    endfunction

    // Storage array; cleared on reset so the head never reads X.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/xbar_route_loader.sv
// Crossbar route loader: turns connect/disconnect/clear-all requests into
// one-cycle toggle pulses on AddressSelect, each followed by a rest cycle,
// while tracking a shadow copy of the crossbar route map.
// Build option: define XBAR_LOADER_FIFO_EN to put a 4-entry request FIFO in
// front of the sequencer (ReqReady then means "FIFO not full").
module xbar_route_loader
    import xbar_route_loader_pkg::*;
#(
    parameter int unsigned IN_CNT    = 3,
    parameter int unsigned OUT_CNT   = 8,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned REST_ADDR = rest_addr(ADDR_W),
    parameter int unsigned IN_W      = clog2(IN_CNT),
    parameter int unsigned OUT_W     = clog2(OUT_CNT)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      ReqValid,
    output logic                      ReqReady,
    input  logic [1:0]                ReqOp,
    input  logic [IN_W-1:0]           ReqIn,
    input  logic [OUT_W-1:0]          ReqOut,
    output logic [ADDR_W-1:0]         AddressSelect,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Err,
    output logic [OUT_CNT-1:0]        MapValid,
    output logic [OUT_CNT*IN_W-1:0]   MapSrc
);

    localparam logic [ADDR_W-1:0] RestAddr = ADDR_W'(REST_ADDR);

    state_e                        state_q, state_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic [OUT_CNT-1:0]            map_valid_q, map_valid_d;
    logic [OUT_CNT-1:0][IN_W-1:0]  map_src_q, map_src_d;
    logic [1:0]                    op_q, op_d;
    logic [IN_W-1:0]               in_q, in_d;
    logic [OUT_W-1:0]              out_q, out_d;
    logic [OUT_W-1:0]              idx_q, idx_d;
    logic                          err_q, err_d;

    // Request as seen by the sequencer (port or FIFO head).
    logic                          req_avail;
    logic [1:0]                    req_op;
    logic [IN_W-1:0]               req_in;
    logic [OUT_W-1:0]              req_out;
    logic                          req_legal;
    logic                          last_idx;

`ifdef XBAR_LOADER_FIFO_EN
    localparam int unsigned ReqW = 2 + IN_W + OUT_W;

    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ReqW-1:0] fifo_rdata;

    assign fifo_push = ReqValid && !fifo_full;
    assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
    assign ReqReady  = !fifo_full;
    assign req_avail = !fifo_empty;
    assign {req_op, req_in, req_out} = fifo_rdata;

    xbar_req_fifo #(
        .Depth (4),
        .Width (ReqW)
    ) u_req_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (fifo_push),
        .wdata ({ReqOp, ReqIn, ReqOut}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    assign ReqReady  = (state_q == StIdle);
    assign req_avail = ReqValid;
    assign req_op    = ReqOp;
    assign req_in    = ReqIn;
    assign req_out   = ReqOut;
`endif

    function automatic logic [ADDR_W-1:0] tog(input logic [IN_W-1:0]  i,
                                              input logic [OUT_W-1:0] o);
        return ADDR_W'(toggle_addr(32'(i), 32'(o), OUT_CNT));
    endfunction

    assign req_legal = (req_op != OP_RSVD) && (32'(req_in) < IN_CNT) &&
                       (32'(req_out) < OUT_CNT);
    assign last_idx  = (32'(idx_q) == OUT_CNT - 1);

    assign AddressSelect = addr_q;
    assign Busy          = (state_q != StIdle);
    assign Done          = (state_q == StDone);
    assign Err           = (state_q == StDone) && err_q;
    assign MapValid      = map_valid_q;
    assign MapSrc        = map_src_q;

    // Next-state logic. A toggle is loaded into addr_d on the same edge that
    // updates the shadow map; every other cycle defaults to the rest address.
    always_comb begin
        state_d     = state_q;
        addr_d      = RestAddr;
        map_valid_d = map_valid_q;
        map_src_d   = map_src_q;
        op_d        = op_q;
        in_d        = in_q;
        out_d       = out_q;
        idx_d       = idx_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_avail) begin
                    op_d  = req_op;
                    in_d  = req_in;
                    out_d = req_out;
                    idx_d = '0;
                    err_d = 1'b0;
                    if (!req_legal) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (req_op == OP_CONNECT) begin
                        if (map_valid_q[req_out] && (map_src_q[req_out] == req_in)) begin
                            state_d = StDone;
                        end else if (map_valid_q[req_out]) begin
                            // Crossbar refuses a connect on a driven output: drop it first.
                            state_d              = StDrop;
                            addr_d               = tog(map_src_q[req_out], req_out);
                            map_valid_d[req_out] = 1'b0;
                            map_src_d[req_out]   = '0;
                        end else begin
                            state_d              = StSet;
                            addr_d               = tog(req_in, req_out);
                            map_valid_d[req_out] = 1'b1;
                            map_src_d[req_out]   = req_in;
                        end
                    end else if (req_op == OP_DISCONNECT) begin
                        if (map_valid_q[req_out] && (map_src_q[req_out] == req_in)) begin
                            state_d              = StDrop;
                            addr_d               = tog(req_in, req_out);
                            map_valid_d[req_out] = 1'b0;
                            map_src_d[req_out]   = '0;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end
                    end else begin
                        state_d = StClr;
                    end
                end
            end
            StDrop: begin
                state_d = StDropGap;
            end
            StDropGap: begin
                if (op_q == OP_CONNECT) begin
                    state_d            = StSet;
                    addr_d             = tog(in_q, out_q);
                    map_valid_d[out_q] = 1'b1;
                    map_src_d[out_q]   = in_q;
                end else begin
                    state_d = StDone;
                end
            end
            StSet: begin
                state_d = StSetGap;
            end
            StSetGap: begin
                state_d = StDone;
            end
            StClr: begin
                if (map_valid_q[idx_q]) begin
                    state_d            = StClrGap;
                    addr_d             = tog(map_src_q[idx_q], idx_q);
                    map_valid_d[idx_q] = 1'b0;
                    map_src_d[idx_q]   = '0;
                end else if (last_idx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + OUT_W'(1);
                end
            end
            StClrGap: begin
                if (last_idx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + OUT_W'(1);
                    state_d = StClr;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Output address, shadow map and latched request fields.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            addr_q      <= RestAddr;
            map_valid_q <= '0;
            map_src_q   <= '0;
            op_q        <= '0;
            in_q        <= '0;
            out_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            map_valid_q <= map_valid_d;
            map_src_q   <= map_src_d;
            op_q        <= op_d;
            in_q        <= in_d;
            out_q       <= out_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/xbar_route_loader.md
Name: xbar_route_loader

Overview:
Configuration sequencer that sits directly upstream of the crossbar and drives its AddressSelect toggle input. It accepts connect, disconnect and clear-all route requests over a valid/ready handshake. It keeps a shadow route map and converts each request into legal toggle-address pulses, each followed by one rest cycle. Because the crossbar refuses a connect on an output already driven by another input, the loader always emits the old connection's toggle before the new one.

Parameters:
IN_CNT, 3, crossbar input count
OUT_CNT, 8, crossbar output count
ADDR_W, 5, AddressSelect width; 2**ADDR_W-1 must be >= IN_CNT*OUT_CNT
REST_ADDR, 2**ADDR_W-1, no-op address; must not equal any in*OUT_CNT+out
IN_W, clog2(IN_CNT), request input-index width
OUT_W, clog2(OUT_CNT), request output-index width

Ports:
Clk  in  1  clock
Rst  in  1  asynchronous active-high reset
ReqValid  in  1  request valid
ReqReady  out  1  request accepted when ReqValid&&ReqReady at posedge
ReqOp  in  2  00 connect, 01 disconnect, 10 clear-all, 11 reserved
ReqIn  in  IN_W  source input index
ReqOut  in  OUT_W  destination output index
AddressSelect  out  ADDR_W  registered; drives the crossbar AddressSelect
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse when a request completes
Err  out  1  one-cycle pulse coincident with Done on a rejected or no-effect request
MapValid  out  OUT_CNT  bit o set when output o is routed
MapSrc  out  OUT_CNT*IN_W  field o = input driving output o

Behaviour:
- Reset (async, Rst only): state IDLE, AddressSelect=REST_ADDR, MapValid=0, MapSrc=0, Done=0, Err=0, Busy=0. The crossbar shares Rst, so both blocks clear together. Reset mid-sequence aborts the sequence with no partial state retained.
- Toggle address = in*OUT_CNT+out.
- AddressSelect holds a toggle value for exactly one cycle, then REST_ADDR. REST_ADDR is the value in every other cycle.
- States: IDLE, DROP, DROP_GAP, SET, SET_GAP, CLR, CLR_GAP, DONE.
- ReqReady=1 only in IDLE (base build). Request fields are latched on accept.
- Connect, output free: SET -> SET_GAP -> DONE. Accept at edge E: AddressSelect=toggle during cycle E+1, Done in cycle E+3.
- Connect, output driven by another input k: DROP (emits k's address) -> DROP_GAP -> SET -> SET_GAP -> DONE.
- Connect, already routed to the same input: DONE directly. No toggle, Err=0.
- Disconnect, routed from ReqIn: DROP -> DROP_GAP -> DONE.
- Disconnect, unrouted or routed from a different input: DONE with Err=1, no toggle.
- Clear-all: a counter idx walks outputs 0..OUT_CNT-1.
  - In CLR, if MapValid[idx]: emit MapSrc[idx]'s toggle and go to CLR_GAP; otherwise advance idx.
  - After the last idx: DONE.
  - Clear-all with an empty map takes OUT_CNT CLR cycles and emits no toggles.
- ReqIn >= IN_CNT, ReqOut >= OUT_CNT, or ReqOp=11: DONE with Err=1, no toggle.
- The shadow map updates on the same edge that loads the toggle into AddressSelect.
- DONE: Done=1, ReqReady=0; next state IDLE.

Optional Feature:
XBAR_LOADER_FIFO_EN:
- Defined: a 4-entry request FIFO sits in front of the FSM. ReqReady = !full. The FSM pops a request when in IDLE and the FIFO is not empty (one cycle of extra latency). A request arriving while the FIFO is full is stalled, never dropped.
- Undefined: no FIFO; ReqReady = (state==IDLE).

Decomposition:
- Shared package:
  - ReqOp encodings (OP_CONNECT, OP_DISCONNECT, OP_CLEAR)
  - FSM state enum
  - REST_ADDR default
  - clog2 helper
  - toggle-address function in*OUT_CNT+out
- Sub-module xbar_req_fifo: synchronous FIFO, async Rst, instantiated only under XBAR_LOADER_FIFO_EN.

Test Plan:
- Reset, idle: AddressSelect=31, MapValid=0, ReqReady=1; connect in1->out2 -> AddressSelect 10 for one cycle, then 31; Done at E+3; MapValid[2]=1, MapSrc[2]=1.
- Reroute: with in1->out2 active, connect in2->out2 -> AddressSelect sequence 10,31,18,31; Done; MapSrc[2]=2; crossbar output 2 carries input 2.
- Disconnect mismatch: with in2->out2 active, disconnect in0/out2 -> no toggle, Done+Err same cycle, map unchanged.
- Clear-all: with routes in2->out2 and in0->out5 -> AddressSelect 18,31,5,31; Done; MapValid=0; crossbar outputs 0.
- Illegal request: ReqIn=3 connect, or ReqOp=11 -> Done+Err, AddressSelect stays 31.
- Reset mid-reroute: assert Rst in the cycle AddressSelect=10 -> immediate REST_ADDR, map cleared, Busy=0; a following connect completes normally.
